// File: rtl/dispatch_ctrl_pkg.sv
// Shared constants for the dispatch controller: data width, RV32I opcodes,
// dispatch class codes and the controller state encoding.
package dispatch_ctrl_pkg;

    localparam int                    DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA  = '0;

    localparam logic [6:0] LUI     = 7'b0110111;
    localparam logic [6:0] AUIPC   = 7'b0010111;
    localparam logic [6:0] JAL     = 7'b1101111;
    localparam logic [6:0] JALR    = 7'b1100111;
    localparam logic [6:0] B_TYPE  = 7'b1100011;
    localparam logic [6:0] LI_TYPE = 7'b0000011;
    localparam logic [6:0] S_TYPE  = 7'b0100011;
    localparam logic [6:0] AI_TYPE = 7'b0010011;
    localparam logic [6:0] R_TYPE  = 7'b0110011;

    typedef enum logic [1:0] {
        CLS_RS  = 2'd0,
        CLS_LSB = 2'd1,
        CLS_ROB = 2'd2,
        CLS_ILL = 2'd3
    } cls_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STALL = 2'd2
    } dstate_t;

endpackage

// File: rtl/dispatch_ctrl_if.sv
// Fetcher-side push channel and decoder-side dispatch channel of dispatch_ctrl.
interface dispatch_ctrl_if;
    import dispatch_ctrl_pkg::*;

    logic                  in_fetch_valid;
    logic [DATA_WIDTH-1:0] in_fetch_instr;
    logic [DATA_WIDTH-1:0] in_fetch_pc;
    logic                  out_fetch_full;
    logic                  out_dec_valid;
    logic [DATA_WIDTH-1:0] out_dec_instr;
    logic [DATA_WIDTH-1:0] out_dec_pc;

    modport master (
        output in_fetch_valid, in_fetch_instr, in_fetch_pc,
        input  out_fetch_full, out_dec_valid, out_dec_instr, out_dec_pc
    );

    modport slave (
        input  in_fetch_valid, in_fetch_instr, in_fetch_pc,
        output out_fetch_full, out_dec_valid, out_dec_instr, out_dec_pc
    );

endinterface

// File: rtl/dispatch_classify.sv
// Combinational opcode classifier: maps an instruction word to the unit that
// must accept it. Also used by the fetcher for predecode.
module dispatch_classify
    import dispatch_ctrl_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] instr,
    output cls_t                  cls
);

    logic [6:0] opcode;
    logic       unused_upper;

    assign opcode       = instr[6:0];
    assign unused_upper = ^instr[DATA_WIDTH-1:7];

    always_comb begin
        cls = CLS_ILL;
        case (opcode)
            LI_TYPE, S_TYPE:                        cls = CLS_LSB;
            LUI, AUIPC:                             cls = CLS_ROB;
            AI_TYPE, R_TYPE, B_TYPE, JALR, JAL:     cls = CLS_RS;
            default:                                cls = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/dispatch_ctrl.sv
// Instruction dispatch controller: fetch FIFO, head classification and gated
// release to the decoder. Optional statistics counters under DISPATCH_STAT_EN.
module dispatch_ctrl
    import dispatch_ctrl_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy,
    dispatch_ctrl_if.slave bus,
    input  logic           in_rob_full,
    input  logic           in_rs_full,
    input  logic           in_lsb_full,
    input  logic           in_flush
`ifdef DISPATCH_STAT_EN
    ,
    output logic [31:0]    out_stat_issued,
    output logic [31:0]    out_stat_rob_stall,
    output logic [31:0]    out_stat_unit_stall
`endif
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_CNT  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_PTR  = ADDR_W'(1);

    logic [DATA_WIDTH-1:0] mem_instr [DEPTH];
    logic [DATA_WIDTH-1:0] mem_pc    [DEPTH];
    logic [ADDR_W-1:0]     head;
    logic [ADDR_W-1:0]     tail;
    logic [ADDR_W:0]       count;
    logic [ADDR_W:0]       count_next;
    dstate_t               state;
    logic                  dec_valid;
    logic [DATA_WIDTH-1:0] dec_instr;
    logic [DATA_WIDTH-1:0] dec_pc;
    cls_t                  head_cls;
    logic                  full;
    logic                  has_head;
    logic                  unit_free;
    logic                  issue;
    logic                  drop;
    logic                  push;
    logic                  pop;
    logic                  unused_state_probe;

    dispatch_classify u_classify (
        .instr (mem_instr[head]),
        .cls   (head_cls)
    );

    assign full     = (count == FULL_CNT);
    assign has_head = (count != '0);

    always_comb begin
        unit_free = 1'b0;
        case (head_cls)
            CLS_ROB: unit_free = 1'b1;
            CLS_RS:  unit_free = !in_rs_full;
            CLS_LSB: unit_free = !in_lsb_full;
            default: unit_free = 1'b0;
        endcase
    end

    // Illegal heads are discarded regardless of back-pressure so they never block the queue.
    assign issue = has_head && !in_rob_full && unit_free;
    assign drop  = has_head && (head_cls == CLS_ILL);
    assign pop   = issue || drop;
    assign push  = bus.in_fetch_valid && !full;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + ONE_CNT;
        end else if (pop && !push) begin
            count_next = count - ONE_CNT;
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && !in_flush && push) begin
            mem_instr[tail] <= bus.in_fetch_instr;
            mem_pc[tail]    <= bus.in_fetch_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            state     <= ST_EMPTY;
            dec_valid <= 1'b0;
            dec_instr <= ZERO_DATA;
            dec_pc    <= ZERO_DATA;
        end else if (rdy) begin
            if (in_flush) begin
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                state     <= ST_EMPTY;
                dec_valid <= 1'b0;
                dec_instr <= ZERO_DATA;
                dec_pc    <= ZERO_DATA;
            end else begin
                if (push) tail <= tail + ONE_PTR;
                if (pop)  head <= head + ONE_PTR;
                count     <= count_next;
                dec_valid <= issue;
                dec_instr <= issue ? mem_instr[head] : ZERO_DATA;
                dec_pc    <= issue ? mem_pc[head]    : ZERO_DATA;
                if (issue)                 state <= ST_ISSUE;
                else if (count_next == '0) state <= ST_EMPTY;
                else                       state <= ST_STALL;
            end
        end else begin
            // Clearing valid/instr while frozen keeps the decoder from re-dispatching the held word.
            dec_valid <= 1'b0;
            dec_instr <= ZERO_DATA;
        end
    end

    // The state register exists for debug probing only; nothing downstream consumes it.
    assign unused_state_probe = ^state;

    assign bus.out_fetch_full = full;
    assign bus.out_dec_valid  = dec_valid;
    assign bus.out_dec_instr  = dec_instr;
    assign bus.out_dec_pc     = dec_pc;

`ifdef DISPATCH_STAT_EN
    logic rob_stall;
    logic unit_stall;

    assign rob_stall  = has_head && in_rob_full;
    assign unit_stall = has_head && !in_rob_full && !unit_free && !drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_stat_issued     <= '0;
            out_stat_rob_stall  <= '0;
            out_stat_unit_stall <= '0;
        end else if (rdy && !in_flush) begin
            if (issue)      out_stat_issued     <= out_stat_issued + 32'd1;
            if (rob_stall)  out_stat_rob_stall  <= out_stat_rob_stall + 32'd1;
            if (unit_stall) out_stat_unit_stall <= out_stat_unit_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Self-checking bench for dispatch_ctrl: directed table, corner-case sequences
// and randomized traffic against a queue-based reference model.
module tb_dispatch_ctrl;

    localparam int DEPTH  = 16;
    localparam int CL_RS  = 0;
    localparam int CL_LSB = 1;
    localparam int CL_ROB = 2;
    localparam int CL_ILL = 3;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic in_rob_full;
    logic in_rs_full;
    logic in_lsb_full;
    logic in_flush;

    dispatch_ctrl_if bus ();

`ifdef DISPATCH_STAT_EN
    logic [31:0] st_issued;
    logic [31:0] st_rob;
    logic [31:0] st_unit;
`endif

    dispatch_ctrl #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .bus         (bus.slave),
        .in_rob_full (in_rob_full),
        .in_rs_full  (in_rs_full),
        .in_lsb_full (in_lsb_full),
        .in_flush    (in_flush)
`ifdef DISPATCH_STAT_EN
        ,
        .out_stat_issued     (st_issued),
        .out_stat_rob_stall  (st_rob),
        .out_stat_unit_stall (st_unit)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      q[$];
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc;

    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        rob;
        logic        rs;
        logic        lsb;
        logic        rdy;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        logic        ef;
    } vec_t;

    vec_t tbl[11];

    function automatic int cls_of(logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        case (op)
            7'b0000011, 7'b0100011: return CL_LSB;
            7'b0110111, 7'b0010111: return CL_ROB;
            7'b0010011, 7'b0110011, 7'b1100011, 7'b1100111, 7'b1101111: return CL_RS;
            default: return CL_ILL;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: queue semantics straight from the dispatch rules, evaluated on pre-edge inputs.
    task automatic model_edge();
        entry_t e;
        int     c;
        bit     issued;
        bit     was_full;
        issued = 1'b0;
        if (!rdy) begin
            m_valid = 1'b0;
            m_instr = 32'h0;
        end else if (in_flush) begin
            q.delete();
            m_valid = 1'b0;
            m_instr = 32'h0;
            m_pc    = 32'h0;
        end else begin
            was_full = (q.size() == DEPTH);
            if (q.size() > 0) begin
                c = cls_of(q[0].instr);
                if (c == CL_ILL) begin
                    q.delete(0);
                end else if (!in_rob_full && (c == CL_ROB || (c == CL_RS && !in_rs_full) ||
                                              (c == CL_LSB && !in_lsb_full))) begin
                    e = q[0];
                    q.delete(0);
                    issued  = 1'b1;
                    m_valid = 1'b1;
                    m_instr = e.instr;
                    m_pc    = e.pc;
                end
            end
            if (!issued) begin
                m_valid = 1'b0;
                m_instr = 32'h0;
                m_pc    = 32'h0;
            end
            if (bus.in_fetch_valid && !was_full) begin
                e.instr = bus.in_fetch_instr;
                e.pc    = bus.in_fetch_pc;
                q.push_back(e);
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_model();
        chk("dec_valid", {31'b0, bus.out_dec_valid}, {31'b0, m_valid});
        chk("dec_instr", bus.out_dec_instr, m_instr);
        chk("dec_pc", bus.out_dec_pc, m_pc);
        chk("fetch_full", {31'b0, bus.out_fetch_full}, {31'b0, (q.size() == DEPTH)});
    endtask

    task automatic drive(logic v, logic [31:0] instr, logic [31:0] pc);
        bus.in_fetch_valid = v;
        bus.in_fetch_instr = instr;
        bus.in_fetch_pc    = pc;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 32'h0, 32'h0);
        rdy         = 1'b1;
        in_rob_full = 1'b0;
        in_rs_full  = 1'b0;
        in_lsb_full = 1'b0;
        in_flush    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        q.delete();
        m_valid = 1'b0;
        m_instr = 32'h0;
        m_pc    = 32'h0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] rnd;
        logic [6:0]  ops[10];
        logic [31:0] pc_ctr;

        rst = 1'b1;
        idle_inputs();
        m_valid = 1'b0;
        m_instr = 32'h0;
        m_pc    = 32'h0;
        #2;
        chk("rst_valid", {31'b0, bus.out_dec_valid}, 32'h0);
        chk("rst_instr", bus.out_dec_instr, 32'h0);
        chk("rst_pc", bus.out_dec_pc, 32'h0);
        chk("rst_full", {31'b0, bus.out_fetch_full}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table: fields v, instr, pc, rob, rs, lsb, rdy | exp valid, instr, pc, full
        tbl[0]  = '{1'b1, 32'h00100093, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0, 1'b0};
        tbl[1]  = '{1'b0, 32'h0,        32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00100093, 32'h0, 1'b0};
        tbl[2]  = '{1'b1, 32'hFFFFFFFF, 32'h4,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0, 1'b0};
        tbl[3]  = '{1'b1, 32'h000012B7, 32'h8,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0, 1'b0};
        tbl[4]  = '{1'b0, 32'h0,        32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h000012B7, 32'h8, 1'b0};
        tbl[5]  = '{1'b0, 32'h0,        32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0, 1'b0};
        tbl[6]  = '{1'b1, 32'h002081B3, 32'hC,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0, 1'b0};
        tbl[7]  = '{1'b1, 32'h00000013, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0, 1'b0};
        tbl[8]  = '{1'b0, 32'h0,        32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h002081B3, 32'hC, 1'b0};
        tbl[9]  = '{1'b0, 32'h0,        32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'hC, 1'b0};
        tbl[10] = '{1'b0, 32'h0,        32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].instr, tbl[i].pc);
            in_rob_full = tbl[i].rob;
            in_rs_full  = tbl[i].rs;
            in_lsb_full = tbl[i].lsb;
            rdy         = tbl[i].rdy;
            in_flush    = 1'b0;
            step();
            chk($sformatf("tbl%0d_valid", i), {31'b0, bus.out_dec_valid}, {31'b0, tbl[i].ev});
            chk($sformatf("tbl%0d_instr", i), bus.out_dec_instr, tbl[i].ei);
            chk($sformatf("tbl%0d_pc", i), bus.out_dec_pc, tbl[i].ep);
            chk($sformatf("tbl%0d_full", i), {31'b0, bus.out_fetch_full}, {31'b0, tbl[i].ef});
        end
        idle_inputs();

        // LW blocked by the LSB for five cycles with an ADD queued behind it.
        in_lsb_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 0)      drive(1'b1, 32'h0000A103, 32'h100);
            else if (i == 1) drive(1'b1, 32'h002081B3, 32'h104);
            else             drive(1'b0, 32'h0, 32'h0);
            step();
            check_model();
            chk("lsb_block_valid", {31'b0, bus.out_dec_valid}, 32'h0);
        end
        drive(1'b0, 32'h0, 32'h0);
        in_lsb_full = 1'b0;
        step();
        check_model();
        chk("lw_issue_instr", bus.out_dec_instr, 32'h0000A103);
        chk("lw_issue_pc", bus.out_dec_pc, 32'h100);
        step();
        check_model();
        chk("add_after_lw_pc", bus.out_dec_pc, 32'h104);

        // Fill to capacity behind a full ROB, push once more, then drain.
        in_rob_full = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'h00000013 | (32'(i) << 20), 32'h200 + 32'(i) * 4);
            step();
            check_model();
        end
        chk("full_after_16", {31'b0, bus.out_fetch_full}, 32'h1);
        drive(1'b1, 32'h00000013, 32'h2FC);
        step();
        check_model();
        chk("full_after_17th", {31'b0, bus.out_fetch_full}, 32'h1);
        drive(1'b0, 32'h0, 32'h0);
        in_rob_full = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            check_model();
            chk("drain_valid", {31'b0, bus.out_dec_valid}, 32'h1);
            chk("drain_pc", bus.out_dec_pc, 32'h200 + 32'(i) * 4);
        end
        chk("full_after_drain", {31'b0, bus.out_fetch_full}, 32'h0);
        step();
        check_model();
        chk("no_17th_issue", {31'b0, bus.out_dec_valid}, 32'h0);

        // Flush with a same-cycle push.
        in_rob_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h00000093, 32'h300 + 32'(i) * 4);
            step();
            check_model();
        end
        drive(1'b1, 32'h00000013, 32'h3FC);
        in_flush = 1'b1;
        step();
        check_model();
        chk("flush_count", {27'b0, dut.count}, 32'h0);
        in_flush    = 1'b0;
        in_rob_full = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_model();
            chk("post_flush_valid", {31'b0, bus.out_dec_valid}, 32'h0);
        end

        // Asynchronous reset while instructions are stalled.
        in_rob_full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h00000093, 32'h400 + 32'(i) * 4);
            step();
            check_model();
        end
        drive(1'b0, 32'h0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_count", {27'b0, dut.count}, 32'h0);
        chk("midrst_valid", {31'b0, bus.out_dec_valid}, 32'h0);
        q.delete();
        m_valid = 1'b0;
        m_instr = 32'h0;
        m_pc    = 32'h0;
        @(negedge clk);
        rst         = 1'b0;
        in_rob_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_model();
        end

        // Randomized traffic against the reference model.
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1111111};
        pc_ctr = 32'h1000;
        for (int n = 0; n < 2000; n++) begin
            rnd = $urandom;
            drive(($urandom_range(0, 99) < 60), {rnd[31:7], ops[$urandom_range(0, 9)]}, pc_ctr);
            pc_ctr      = pc_ctr + 32'h4;
            in_rob_full = ($urandom_range(0, 99) < 30);
            in_rs_full  = ($urandom_range(0, 99) < 25);
            in_lsb_full = ($urandom_range(0, 99) < 25);
            in_flush    = ($urandom_range(0, 99) < 2);
            rdy         = ($urandom_range(0, 99) < 90);
            step();
            check_model();
        end
        idle_inputs();

`ifdef DISPATCH_STAT_EN
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(1'b1, 32'h00100093, 32'h500 + 32'(i) * 4);
            else       drive(1'b0, 32'h0, 32'h0);
            step();
            check_model();
        end
        drive(1'b1, 32'h00100093, 32'h50C);
        in_rob_full = 1'b1;
        step();
        drive(1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_model();
        end
        chk("stat_issued", st_issued, 32'd3);
        chk("stat_rob_stall", st_rob, 32'd4);
        chk("stat_unit_stall", st_unit, 32'd0);
        idle_inputs();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
